avr_io_crcdma: RTL and testbench
================================

# avr_io_crcdma

Memory-to-CRC sequencer. Software programs a start address and byte count, then the block fetches bytes from data memory over a request/grant read port and feeds them to the CRC peripheral's write interface. It paces each byte to the CRC engine's 4-cycle processing window, and can pre-initialise and post-invert the CRC. It sits on the AVR I/O bus beside the CRC peripheral and owns that peripheral's write port while busy.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- io_re  in  1  CPU register read strobe
- io_we  in  1  CPU register write strobe
- io_a  in  3  register select: 0 ADDRL, 1 ADDRH, 2 LENL, 3 LENH, 4 CTRL, 5 STATUS
- io_di  in  8  CPU write data
- io_do  out  8  CPU read data; 0 when io_re=0
- mem_req  out  1  memory read request
- mem_a  out  16  memory byte address, stable while mem_req=1
- mem_gnt  in  1  grant; mem_d valid in the same cycle
- mem_d  in  8  memory read data
- crc_we  out  1  write strobe to CRC peripheral
- crc_a  out  2  CRC register address (0 = data, 1 = control)
- crc_di  out  8  CRC write data
- irq  out  1  interrupt, level

## Operation
- Registers
  - ADDR (16 b) and LEN (16 b) read back live: the current address and the remaining count.
  - CPU writes to ADDR/LEN while busy are ignored.
- CTRL write bits (bits not listed read as 0):
  - bit0 START
  - bit1 INIT: write 0x02 to CRC control first, which presets the CRC to 0xFFFFFFFF.
  - bit2 INV: write 0x01 to CRC control at the end, which complements the CRC.
  - bit3 IE: stored and readable.
  - bit7 ABORT
- STATUS: bit0 BUSY (read-only), bit1 DONE. Writing 1 to bit1 clears DONE.
- States and transitions:
  - IDLE → INIT on START with INIT=1, otherwise → FETCH on START.
  - INIT → FETCH.
  - FETCH → FEED on mem_gnt.
  - FEED → WAIT.
  - WAIT → FETCH after 4 cycles when LEN≠0, otherwise → FINAL.
  - FINAL → IDLE.
- Entry from IDLE goes directly to FINAL when LEN=0.
- FINAL issues the CRC write only when INV=1. FINAL always sets DONE.
- INIT: one cycle, crc_we=1, crc_a=1, crc_di=0x02.
- FETCH:
  - mem_req=1, mem_a=ADDR, held until mem_gnt.
  - On mem_gnt: capture mem_d, ADDR+1 (wraps 0xFFFF→0x0000), LEN−1.
- FEED: one cycle, crc_we=1, crc_a=0, crc_di=captured byte.
- WAIT: 4 cycles with crc_we=0, so the CRC engine completes its 4 processing steps.
- crc_we=0 in every state except INIT, FEED and FINAL (when INV=1). crc_a and crc_di are 0 whenever crc_we=0.
- irq = DONE & IE.
- Boundary rules:
  - START while busy is ignored.
  - START and ABORT in the same write: ABORT wins, and the block stays or returns to IDLE.
  - ABORT from any state:
    - Next state is IDLE; mem_req drops the next cycle.
    - DONE is not set. ADDR/LEN keep their current values.
  - START while DONE=1: DONE is cleared on START.
  - A DONE-clear write in the same cycle as FINAL: set wins.
  - mem_gnt outside FETCH is ignored.
  - Reset mid-operation: immediate return to IDLE with all registers reset.
- Software must not access the CRC peripheral while BUSY=1. The top level ORs crc_* with the CPU's strobes.

## Timing
- Reset values:
  - state IDLE; ADDR=0, LEN=0, CTRL=0, DONE=0.
  - mem_req=0, mem_a=0, crc_we=0, crc_a=0, crc_di=0, irq=0, io_do=0.
- io_do is combinational from io_a and io_re.
- Register writes take effect at the clock edge with io_we=1.
- START written at edge T:
  - BUSY=1 from T.
  - With INIT=1: crc_we at cycle T+1, first mem_req at T+2.
  - With INIT=0: first mem_req at T+1.
- Per byte with immediate grant: FETCH 1 + FEED 1 + WAIT 4 = 6 cycles. Each grant-wait cycle adds 1.
- Consecutive crc_we data strobes are ≥5 cycles apart.
- FINAL follows the last WAIT cycle. DONE and irq assert at the edge leaving FINAL, and BUSY clears at that same edge.
- N bytes, INIT=1, immediate grant: START to DONE = 1 + 6N + 1 cycles.

## Test plan
- Reset (rst=0 asynchronously mid-transfer):
  - All outputs go to their reset values without waiting for a clock.
  - Register reads return 0.
- ADDR=0x0100, LEN=9, bytes "123456789", CTRL=0x0F, grant always 1:
  - The CRC peripheral reads 0xE3069283 (CRC-32C check).
  - DONE and irq=1 after 56 cycles.
  - ADDR=0x0109, LEN=0.
- LEN=0, CTRL=0x07:
  - Exactly two crc_we strobes (0x02, then 0x01), no mem_req, DONE=1.
- ADDR=0xFFFF, LEN=2, grant delayed 3 cycles per fetch:
  - mem_a sequence is 0xFFFF then 0x0000, with mem_a stable across the wait.
  - Data strobes are 9 cycles apart.
- ABORT written during the 2nd WAIT of a 4-byte job:
  - BUSY=0 next cycle, DONE=0, LEN reads 2.
  - No further crc_we.
  - A subsequent START completes normally.
- Busy writes:
  - START while busy: no effect.
  - ADDR/LEN write while busy: ignored.
  - DONE-clear coincident with FINAL: DONE stays 1.

Source files
------------

// File: rtl/avr_io_crcdma.sv
// Memory-to-CRC sequencer on the AVR I/O bus: fetches LEN bytes from ADDR over a
// request/grant port and feeds them, paced, to the CRC peripheral's write port.
module avr_io_crcdma (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [2:0]  io_a,
  input  logic [7:0]  io_di,
  output logic [7:0]  io_do,
  output logic        mem_req,
  output logic [15:0] mem_a,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_d,
  output logic        crc_we,
  output logic [1:0]  crc_a,
  output logic [7:0]  crc_di,
  output logic        irq,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FETCH = 3'd2,
    S_FEED  = 3'd3,
    S_WAIT  = 3'd4,
    S_FINAL = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [15:0] addr, len;
  logic [7:0]  data_q;
  logic [1:0]  wait_cnt;
  logic        ctl_init, ctl_inv, ctl_ie, done;

  logic ctrl_wr, abort, start_ok, busy, grant;

  assign busy     = (state != S_IDLE);
  assign ctrl_wr  = io_we && (io_a == 3'd4);
  assign abort    = ctrl_wr && io_di[7];
  assign start_ok = ctrl_wr && io_di[0] && !io_di[7] && !busy;
  // Memory handshake: mem_req/mem_a hold steady until mem_gnt; the beat transfers
  // (mem_d sampled) in the cycle where both mem_req and mem_gnt are high.
  assign grant    = (state == S_FETCH) && mem_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (io_di[1])          state_nx = S_INIT;
          else if (len == 16'd0) state_nx = S_FINAL;
          else                   state_nx = S_FETCH;
        end
      end
      S_INIT:  state_nx = (len == 16'd0) ? S_FINAL : S_FETCH;
      S_FETCH: if (mem_gnt) state_nx = S_FEED;
      S_FEED:  state_nx = S_WAIT;
      S_WAIT:  if (wait_cnt == 2'd3) state_nx = (len != 16'd0) ? S_FETCH : S_FINAL;
      S_FINAL: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= 16'h0000;
      len      <= 16'h0000;
      data_q   <= 8'h00;
      wait_cnt <= 2'd0;
      ctl_init <= 1'b0;
      ctl_inv  <= 1'b0;
      ctl_ie   <= 1'b0;
      done     <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 2'd1 : 2'd0;
      if (grant) begin
        data_q <= mem_d;
        addr   <= addr + 16'd1;
        len    <= len - 16'd1;
      end else if (io_we && !busy) begin
        case (io_a)
          3'd0:    addr[7:0]  <= io_di;
          3'd1:    addr[15:8] <= io_di;
          3'd2:    len[7:0]   <= io_di;
          3'd3:    len[15:8]  <= io_di;
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        ctl_init <= io_di[1];
        ctl_inv  <= io_di[2];
        ctl_ie   <= io_di[3];
      end
      // Completion outranks a same-cycle software clear; an abort never completes.
      if (state == S_FINAL && !abort)           done <= 1'b1;
      else if (start_ok)                        done <= 1'b0;
      else if (io_we && io_a == 3'd5 && io_di[1]) done <= 1'b0;
    end
  end

  always_comb begin
    mem_req = (state == S_FETCH);
    mem_a   = mem_req ? addr : 16'h0000;
    crc_we  = 1'b0;
    crc_a   = 2'd0;
    crc_di  = 8'h00;
    case (state)
      S_INIT: begin
        crc_we = 1'b1;
        crc_a  = 2'd1;
        crc_di = 8'h02;
      end
      S_FEED: begin
        crc_we = 1'b1;
        crc_di = data_q;
      end
      S_FINAL: begin
        if (ctl_inv) begin
          crc_we = 1'b1;
          crc_a  = 2'd1;
          crc_di = 8'h01;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    io_do = 8'h00;
    if (io_re) begin
      case (io_a)
        3'd0:    io_do = addr[7:0];
        3'd1:    io_do = addr[15:8];
        3'd2:    io_do = len[7:0];
        3'd3:    io_do = len[15:8];
        3'd4:    io_do = {4'b0000, ctl_ie, ctl_inv, ctl_init, 1'b0};
        3'd5:    io_do = {6'b000000, done, busy};
        default: io_do = 8'h00;
      endcase
    end
  end

  assign irq       = done & ctl_ie;
  assign dbg_state = state;

endmodule

// File: tb/tb_avr_io_crcdma.sv
// Directed bench for avr_io_crcdma: memory and CRC-32C peripheral models, register
// driver tasks, directed transfers with hand-computed expectations.
module tb_avr_io_crcdma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        io_re = 1'b0;
  logic        io_we = 1'b0;
  logic [2:0]  io_a = 3'd0;
  logic [7:0]  io_di = 8'h00;
  logic [7:0]  io_do;
  logic        mem_req;
  logic [15:0] mem_a;
  logic        mem_gnt;
  logic [7:0]  mem_d;
  logic        crc_we;
  logic [1:0]  crc_a;
  logic [7:0]  crc_di;
  logic        irq;
  logic [2:0]  dbg_state;

  avr_io_crcdma dut (
    .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
    .io_di(io_di), .io_do(io_do), .mem_req(mem_req), .mem_a(mem_a),
    .mem_gnt(mem_gnt), .mem_d(mem_d), .crc_we(crc_we), .crc_a(crc_a),
    .crc_di(crc_di), .irq(irq), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model with programmable grant latency
  logic [7:0] mem [0:65535];
  int gnt_delay = 0;
  int gnt_cnt = 0;
  always @(posedge clk) begin
    if (!mem_req || mem_gnt) gnt_cnt <= 0;
    else                     gnt_cnt <= gnt_cnt + 1;
  end
  assign mem_gnt = mem_req && (gnt_cnt >= gnt_delay);
  assign mem_d   = mem[mem_a];

  // CRC-32C peripheral model and bus logs
  logic [31:0] crc_m = 32'h0;
  logic [9:0]  strobe_q[$];
  logic [15:0] req_q[$];
  int          req_cyc_q[$];
  int          data_cyc_q[$];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'h82F63B78) : (r >> 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (crc_we) begin
        strobe_q.push_back({crc_a, crc_di});
        if (crc_a == 2'd1) begin
          if (crc_di == 8'h02)      crc_m = 32'hFFFFFFFF;
          else if (crc_di == 8'h01) crc_m = ~crc_m;
        end else if (crc_a == 2'd0) begin
          crc_m = crc_byte(crc_m, crc_di);
          data_cyc_q.push_back(cyc);
        end
      end
      if (mem_req) begin
        req_q.push_back(mem_a);
        req_cyc_q.push_back(cyc);
      end
    end
  end

  // scoreboard counters
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called just after a rising edge; a write lands on the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    io_a  = a;
    io_di = d;
    io_we = 1'b1;
    @(posedge clk);
    #1;
    io_we = 1'b0;
    io_di = 8'h00;
    io_a  = 3'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    io_a  = a;
    io_re = 1'b1;
    #1;
    d     = io_do;
    io_re = 1'b0;
    io_a  = 3'd0;
  endtask

  task automatic rd16(input logic [2:0] a, output logic [15:0] v);
    logic [7:0] lo, hi;
    rd(a, lo);
    rd(3'(a + 3'd1), hi);
    v = {hi, lo};
  endtask

  task automatic wait_done(input int max_cyc, output int dcyc);
    logic [7:0] s;
    dcyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      rd(3'd5, s);
      if (s[1]) begin
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    strobe_q.delete();
    req_q.delete();
    req_cyc_q.delete();
    data_cyc_q.delete();
  endtask

  initial begin
    string       msg;
    logic [7:0]  b;
    logic [15:0] w;
    int          t0, d, g, rcount;

    // reset state
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_crc_we", crc_we, 0);
    check("rst_irq", irq, 0);
    check("rst_io_do_idle", io_do, 0);
    rd(3'd5, b); check("rst_status", b, 0);
    #3 rst = 1'b1;
    step();

    // 9-byte CRC-32C check string, INIT+INV+IE, immediate grant
    msg = "123456789";
    for (int i = 0; i < 9; i++) mem[16'h0100 + 16'(i)] = msg[i];
    wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h09); wr(3'd3, 8'h00);
    clear_logs();
    crc_m = 32'h0;
    wr(3'd4, 8'h0F);
    t0 = cyc;
    wait_done(100, d);
    check("a_done_latency", d - t0, 56);
    check("a_irq", irq, 1);
    check("a_crc32c", crc_m, 32'hE3069283);
    check("a_first_req", (req_cyc_q.size() > 0) ? req_cyc_q[0] - t0 : -1, 1);
    check("a_first_strobe", strobe_q[0], 10'h102);
    check("a_strobes", strobe_q.size(), 11);
    g = 1000;
    for (int i = 1; i < data_cyc_q.size(); i++)
      if (data_cyc_q[i] - data_cyc_q[i-1] < g) g = data_cyc_q[i] - data_cyc_q[i-1];
    check("a_min_gap", g, 6);
    rd16(3'd0, w); check("a_addr", w, 16'h0109);
    rd16(3'd2, w); check("a_len", w, 16'h0000);
    rd(3'd4, b); check("a_ctrl", b, 8'h0E);
    step();

    // LEN=0 with INIT+INV: only the two control strobes
    wr(3'd5, 8'h02);
    rd(3'd5, b); check("b_done_clr", b, 8'h00);
    check("b_irq_clr", irq, 0);
    clear_logs();
    wr(3'd4, 8'h07);
    t0 = cyc;
    wait_done(20, d);
    check("b_done_latency", d - t0, 2);
    check("b_strobes", strobe_q.size(), 2);
    check("b_strobe0", strobe_q[0], 10'h102);
    check("b_strobe1", strobe_q[1], 10'h101);
    check("b_no_req", req_q.size(), 0);
    rd(3'd5, b); check("b_status", b, 8'h02);
    check("b_irq_off", irq, 0);
    step();

    // address wrap with 3-cycle grant latency; START while DONE=1 clears DONE
    mem[16'hFFFF] = 8'hA5;
    mem[16'h0000] = 8'h3C;
    gnt_delay = 3;
    wr(3'd0, 8'hFF); wr(3'd1, 8'hFF); wr(3'd2, 8'h02); wr(3'd3, 8'h00);
    clear_logs();
    wr(3'd4, 8'h01);
    t0 = cyc;
    rd(3'd5, b); check("c_busy_done_clr", b, 8'h01);
    wait_done(60, d);
    check("c_done_latency", d - t0, 19);
    check("c_first_req", (req_cyc_q.size() > 0) ? req_cyc_q[0] - t0 : -1, 0);
    check("c_req_cycles", req_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("c_mem_a%0d", i), req_q[i], (i < 4) ? 16'hFFFF : 16'h0000);
    check("c_data0", strobe_q[0], 10'h0A5);
    check("c_data1", strobe_q[1], 10'h03C);
    check("c_gap", (data_cyc_q.size() == 2) ? data_cyc_q[1] - data_cyc_q[0] : -1, 9);
    rd16(3'd0, w); check("c_addr", w, 16'h0001);
    step();

    // ABORT in the second byte's WAIT of a 4-byte job, then resume
    gnt_delay = 0;
    mem[16'h0200] = 8'h11; mem[16'h0201] = 8'h22;
    mem[16'h0202] = 8'h33; mem[16'h0203] = 8'h44;
    wr(3'd5, 8'h02);
    wr(3'd0, 8'h00); wr(3'd1, 8'h02); wr(3'd2, 8'h04); wr(3'd3, 8'h00);
    clear_logs();
    wr(3'd4, 8'h01);
    for (int i = 0; i < 40 && data_cyc_q.size() < 2; i++) step();
    check("d_in_wait", dbg_state, 3'd4);
    wr(3'd4, 8'h80);
    rd(3'd5, b); check("d_abort_status", b, 8'h00);
    rd16(3'd2, w); check("d_abort_len", w, 16'h0002);
    rd16(3'd0, w); check("d_abort_addr", w, 16'h0202);
    rcount = req_q.size();
    for (int i = 0; i < 20; i++) step();
    check("d_no_crc_we", strobe_q.size(), 2);
    check("d_no_req", rcount, 2);
    check("d_no_req_after", req_q.size(), 2);
    wr(3'd4, 8'h01);
    t0 = cyc;
    wait_done(40, d);
    check("d_resume_latency", d - t0, 13);
    check("d_resume_data2", strobe_q[2], 10'h033);
    check("d_resume_data3", strobe_q[3], 10'h044);
    rd16(3'd2, w); check("d_resume_len", w, 16'h0000);
    step();

    // writes while busy, DONE-clear coincident with FINAL, ABORT+START together
    mem[16'h0300] = 8'h5A;
    wr(3'd0, 8'h00); wr(3'd1, 8'h03); wr(3'd2, 8'h01); wr(3'd3, 8'h00);
    clear_logs();
    wr(3'd4, 8'h01);
    wr(3'd2, 8'h55);
    wr(3'd0, 8'h77);
    wr(3'd4, 8'h01);
    step(); step(); step();
    wr(3'd5, 8'h02);
    rd(3'd5, b); check("e_done_set_wins", b, 8'h02);
    rd16(3'd2, w); check("e_len_ignored", w, 16'h0000);
    rd16(3'd0, w); check("e_addr_ignored", w, 16'h0301);
    for (int i = 0; i < 10; i++) step();
    check("e_one_strobe", strobe_q.size(), 1);
    check("e_strobe", strobe_q[0], 10'h05A);
    wr(3'd4, 8'h81);
    rd(3'd5, b); check("e_abort_start", b, 8'h02);
    step();

    // asynchronous reset in the middle of a transfer
    wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h09); wr(3'd3, 8'h00);
    wr(3'd4, 8'h0F);
    step();
    check("f_pre_req", mem_req, 1);
    check("f_pre_mem_a", mem_a, 16'h0100);
    #2 rst = 1'b0;
    #1;
    check("f_mem_req", mem_req, 0);
    check("f_mem_a", mem_a, 0);
    check("f_crc_we", crc_we, 0);
    check("f_crc_di", crc_di, 0);
    check("f_state", dbg_state, 0);
    for (int i = 0; i < 6; i++) begin
      rd(3'(i), b);
      check($sformatf("f_reg%0d", i), b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
